// File: rtl/ecb_stream_ctrl.sv
// ECB-style stream controller: XORs each accepted word with a repeating key.
// Optional: define ECB_CTRL_KEY_ROTATE_EN to rotate the key left by one bit after every delivered word.
module ecb_stream_ctrl #(
  parameter int BLOCK_SIZE = 8,
  parameter int SYNC_SIZE  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BLOCK_SIZE-1:0] key_in,
  input  logic                  key_load,
  output logic                  key_ready,
  input  logic [SYNC_SIZE-1:0]  in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [SYNC_SIZE-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           blk_count
);

  typedef enum logic [1:0] {
    NOKEY = 2'd0,
    IDLE  = 2'd1,
    CRYPT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [BLOCK_SIZE-1:0] r_key;
  logic [SYNC_SIZE-1:0]  r_plain;
  logic [SYNC_SIZE-1:0]  r_out_data;
  logic [15:0]           r_blk_count;

  logic                  w_key_we;
  logic                  w_plain_we;
  logic                  w_dp_en;
  logic                  w_hs;
  logic                  w_key_ready;
  logic                  w_in_ready;
  logic [SYNC_SIZE-1:0]  w_key_rep;

  // Key bit i % BLOCK_SIZE lines up under data bit i.
  generate
    for (genvar gi = 0; gi < SYNC_SIZE; gi++) begin : g_key_rep
      assign w_key_rep[gi] = r_key[gi % BLOCK_SIZE];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_key_we     = 1'b0;
    w_plain_we   = 1'b0;
    w_dp_en      = 1'b0;
    w_hs         = 1'b0;
    w_key_ready  = 1'b0;
    w_in_ready   = 1'b0;
    case (r_state)
      NOKEY: begin
        w_key_ready = 1'b1;
        if (key_load) begin
          w_key_we     = 1'b1;
          w_state_next = IDLE;
        end
      end
      IDLE: begin
        w_key_ready = 1'b1;
        // A key reload wins over a pending word and blocks acceptance this cycle.
        w_in_ready  = ~key_load;
        if (key_load) begin
          w_key_we = 1'b1;
        end else if (in_valid) begin
          w_plain_we   = 1'b1;
          w_state_next = CRYPT;
        end
      end
      CRYPT: begin
        w_dp_en      = 1'b1;
        w_state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          w_hs         = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = NOKEY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= NOKEY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key <= '0;
    end else if (w_key_we) begin
      r_key <= key_in;
`ifdef ECB_CTRL_KEY_ROTATE_EN
    end else if (w_hs) begin
      r_key <= {r_key[BLOCK_SIZE-2:0], r_key[BLOCK_SIZE-1]};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_plain <= '0;
    end else if (w_plain_we) begin
      r_plain <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data <= '0;
    end else if (w_dp_en) begin
      r_out_data <= r_plain ^ w_key_rep;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk_count <= 16'h0000;
    end else if (w_hs) begin
      r_blk_count <= r_blk_count + 16'h0001;
    end
  end

  assign key_ready = w_key_ready;
  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_out_data;
  assign blk_count = r_blk_count;

endmodule

// File: tb/tb_ecb_stream_ctrl.sv
// Randomized self-checking bench for ecb_stream_ctrl (BLOCK_SIZE=8, SYNC_SIZE=32).
module tb_ecb_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  key_in = 8'h00;
  logic        key_load = 1'b0;
  logic        key_ready;
  logic [31:0] in_data = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] blk_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  m_key = 8'h00;
  logic [15:0] m_cnt = 16'h0000;

  ecb_stream_ctrl #(.BLOCK_SIZE(8), .SYNC_SIZE(32)) dut (
    .clk(clk), .rst(rst),
    .key_in(key_in), .key_load(key_load), .key_ready(key_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] cipher(input logic [31:0] p, input logic [7:0] k);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = p[i] ^ k[i % 8];
    return r;
  endfunction

  task automatic advance_key_after_word();
    m_cnt = m_cnt + 16'd1;
`ifdef ECB_CTRL_KEY_ROTATE_EN
    m_key = {m_key[6:0], m_key[7]};
`endif
  endtask

  task automatic load_key(input logic [7:0] k, input logic with_valid);
    @(negedge clk);
    key_in = k; key_load = 1'b1; in_valid = with_valid; in_data = $urandom;
    #1;
    chk("key_ready_on_load", 32'(key_ready), 32'd1);
    chk("in_ready_during_load", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    key_load = 1'b0; in_valid = 1'b0;
    m_key = k;
    chk("idle_after_load", 32'(key_ready), 32'd1);
    chk("no_valid_after_load", 32'(out_valid), 32'd0);
    $display("key load %h (in_valid=%0d)", k, with_valid);
  endtask

  task automatic send_word(input logic [31:0] d, input int stall);
    logic [31:0] exp;
    @(negedge clk);
    in_data = d; in_valid = 1'b1;
    #1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    exp = cipher(d, m_key);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = $urandom;
    chk("crypt_no_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("out_data", out_data, exp);
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      key_load  = 1'($urandom_range(0, 1));
      key_in    = 8'($urandom);
      #1;
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_key_ready", 32'(key_ready), 32'd0);
      @(posedge clk); #1;
      key_load = 1'b0;
      chk("hold_valid_stall", 32'(out_valid), 32'd1);
      chk("hold_stable", out_data, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    advance_key_after_word();
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("blk_count", 32'(blk_count), 32'(m_cnt));
    $display("word in=%h out=%h exp=%h stall=%0d count=%h", d, out_data, exp, stall, blk_count);
  endtask

  initial begin
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_count", 32'(blk_count), 32'd0);
    chk("rst_key_ready", 32'(key_ready), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Words offered before any key are ignored.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = $urandom;
      #1;
      chk("nokey_in_ready", 32'(in_ready), 32'd0);
      chk("nokey_out_valid", 32'(out_valid), 32'd0);
    end
    load_key(8'hA5, 1'b1);
    send_word(32'h00000000, 0);
    chk("first_word_literal", out_data, 32'hA5A5A5A5);
    send_word(32'h00000000, 0);
`ifdef ECB_CTRL_KEY_ROTATE_EN
    chk("second_word_literal", out_data, 32'h4B4B4B4B);
`else
    chk("second_word_literal", out_data, 32'hA5A5A5A5);
`endif
    load_key(8'hA5, 1'b0);
    send_word(32'hFFFF0000, 5);

    // Key reload in IDLE while a word is pending.
    load_key(8'h3C, 1'b1);
    send_word(32'h12345678, 1);

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 2) == 0) load_key(8'($urandom), 1'($urandom_range(0, 1)));
      send_word($urandom, $urandom_range(0, 3));
    end

    // Counter wrap: preload near the top, then deliver two words.
    @(negedge clk);
    force dut.r_blk_count = 16'hFFFE;
    #1;
    release dut.r_blk_count;
    m_cnt = 16'hFFFE;
    chk("preload_count", 32'(blk_count), 32'h0000FFFE);
    send_word($urandom, 0);
    send_word($urandom, 1);

    // Reset while holding a word discards it.
    @(negedge clk);
    in_data = $urandom; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_hold", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    chk("rst_hold_count", 32'(blk_count), 32'd0);
    chk("rst_hold_key_ready", 32'(key_ready), 32'd1);
    chk("rst_hold_in_ready", 32'(in_ready), 32'd0);
    chk("rst_hold_out_data", out_data, 32'h0);
    @(negedge clk); rst = 1'b0;
    m_cnt = 16'h0000; m_key = 8'h00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd0);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    load_key(8'h81, 1'b0);
    send_word($urandom, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
